// File: rtl/ast_width_extender_mc.sv
// ast_width_extender_mc: multi-channel Avalon-ST width extender.
// Packs DATA_IN_W-bit beats into DATA_OUT_W-bit words, one partial-word accumulator per
// channel slot, with beat-level channel interleaving and protocol-error flagging.
// Optional feature macro: AST_WEXT_MC_ERR_CNT_EN enables the saturating err_cnt_o counter;
// when undefined err_cnt_o is tied to zero.
module ast_width_extender_mc #(
    parameter int unsigned DATA_IN_W   = 64,
    parameter int unsigned DATA_OUT_W  = 256,
    parameter int unsigned EMPTY_IN_W  = (DATA_IN_W / 8 > 1) ? $clog2(DATA_IN_W / 8) : 1,
    parameter int unsigned EMPTY_OUT_W = (DATA_OUT_W / 8 > 1) ? $clog2(DATA_OUT_W / 8) : 1,
    parameter int unsigned CHANNEL_W   = 10,
    parameter int unsigned CH_NUM      = 4
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i,
    output logic                   err_o,
    output logic [15:0]            err_cnt_o
);

    localparam int unsigned RATIO    = DATA_OUT_W / DATA_IN_W;
    localparam int unsigned IDX_W    = $clog2(RATIO);
    localparam int unsigned SLOT_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int unsigned BYTES_IN = DATA_IN_W / 8;

    // Per-slot state
    logic [DATA_OUT_W-1:0] acc_q   [CH_NUM];
    logic [IDX_W-1:0]      idx_q   [CH_NUM];
    logic [CHANNEL_W-1:0]  chan_q  [CH_NUM];
    logic [CH_NUM-1:0]     open_q;
    logic [CH_NUM-1:0]     first_q;

    // Output register
    logic                   out_valid_q, out_valid_d;
    logic [DATA_OUT_W-1:0]  out_data_q, out_data_d;
    logic                   out_sop_q, out_sop_d;
    logic                   out_eop_q, out_eop_d;
    logic [EMPTY_OUT_W-1:0] out_empty_q, out_empty_d;
    logic [CHANNEL_W-1:0]   out_chan_q, out_chan_d;
    logic                   err_q, err_d;

    // Next values for the addressed slot
    logic [SLOT_W-1:0]     slot;
    logic                  accept;
    logic                  slot_we;
    logic                  take;
    logic                  done;
    logic                  word_sop;
    logic [IDX_W-1:0]      beat_idx;
    logic [DATA_OUT_W-1:0] acc_nx;
    logic [IDX_W-1:0]      idx_nx;
    logic [CHANNEL_W-1:0]  chan_nx;
    logic                  open_nx;
    logic                  first_nx;

    // Single-slot builds must not index past slot 0
    if (CH_NUM > 1) begin : g_slot
        assign slot = ast_channel_i[SLOT_W-1:0];
    end else begin : g_slot_one
        assign slot = '0;
    end

    // Ready is forced low while reset is held
    assign ast_ready_o = arst_n_i & (~out_valid_q | ast_ready_i);
    assign accept      = ast_valid_i & ast_ready_o;

    // Decode the accepted beat against its slot and build the slot's next state
    always_comb begin
        slot_we  = 1'b0;
        take     = 1'b0;
        done     = 1'b0;
        err_d    = 1'b0;
        word_sop = 1'b0;
        beat_idx = '0;
        acc_nx   = acc_q[slot];
        idx_nx   = idx_q[slot];
        chan_nx  = chan_q[slot];
        open_nx  = open_q[slot];
        first_nx = first_q[slot];
        if (accept) begin
            if (ast_startofpacket_i) begin
                // SOP on an open slot discards the old partial word but still opens
                err_d    = open_q[slot];
                take     = 1'b1;
                beat_idx = '0;
                chan_nx  = ast_channel_i;
                open_nx  = 1'b1;
                first_nx = 1'b1;
                word_sop = 1'b1;
            end else if (open_q[slot] && (chan_q[slot] == ast_channel_i)) begin
                take     = 1'b1;
                beat_idx = idx_q[slot];
                word_sop = first_q[slot];
            end else begin
                err_d = 1'b1;
            end
        end
        if (take) begin
            slot_we = 1'b1;
            acc_nx[32'(beat_idx) * DATA_IN_W +: DATA_IN_W] = ast_data_i;
            done = ast_endofpacket_i | (beat_idx == IDX_W'(RATIO - 1));
            if (done) begin
                idx_nx   = '0;
                first_nx = 1'b0;
                open_nx  = ~ast_endofpacket_i;
            end else begin
                idx_nx = beat_idx + IDX_W'(1);
            end
        end
    end

    // Load a completed word into the output register, otherwise drain on pop
    always_comb begin
        out_valid_d = out_valid_q & ~ast_ready_i;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_empty_d = out_empty_q;
        out_chan_d  = out_chan_q;
        if (done) begin
            out_valid_d = 1'b1;
            out_data_d  = acc_nx;
            out_sop_d   = word_sop;
            out_eop_d   = ast_endofpacket_i;
            out_chan_d  = chan_nx;
            if (ast_endofpacket_i) begin
                out_empty_d = EMPTY_OUT_W'((RATIO - 1 - 32'(beat_idx)) * BYTES_IN
                                           + 32'(ast_empty_i));
            end else begin
                out_empty_d = '0;
            end
        end
    end

    // Slot state registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            for (int i = 0; i < int'(CH_NUM); i++) begin
                acc_q[i]  <= '0;
                idx_q[i]  <= '0;
                chan_q[i] <= '0;
            end
            open_q  <= '0;
            first_q <= '0;
        end else if (slot_we) begin
            acc_q[slot]   <= acc_nx;
            idx_q[slot]   <= idx_nx;
            chan_q[slot]  <= chan_nx;
            open_q[slot]  <= open_nx;
            first_q[slot] <= first_nx;
        end
    end

    // Output and error registers
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
            out_chan_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_empty_q <= out_empty_d;
            out_chan_q  <= out_chan_d;
            err_q       <= err_d;
        end
    end

`ifdef AST_WEXT_MC_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    // Saturating error counter, cleared only by reset
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            err_cnt_q <= '0;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign ast_data_o          = out_data_q;
    assign ast_startofpacket_o = out_sop_q;
    assign ast_endofpacket_o   = out_eop_q;
    assign ast_valid_o         = out_valid_q;
    assign ast_empty_o         = out_empty_q;
    assign ast_channel_o       = out_chan_q;
    assign err_o               = err_q;

endmodule
